// File: rtl/accu_8bit_if.sv
// Handshake bundle for the group accumulator: upstream operand beats in,
// group sums out, with valid/ready flow control on both sides.
interface accu_8bit_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 10
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic [OUT_W-1:0] data_out;
    logic             valid_out;
    logic             ready_in;

    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, data_out, valid_out
    );

    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out
    );
endinterface

// File: rtl/accu_8bit.sv
// Sums GROUP unsigned operand beats into one OUT_W-bit result and presents it
// with valid/ready; a beat arriving while the result drains starts the next group.
module accu_8bit #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic       clk,
    input  logic       rst,
    accu_8bit_if.slave bus
);
    localparam int OUT_W = WIDTH + $clog2(GROUP);
    localparam int CNT_W = $clog2(GROUP);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_data_out;

    logic             w_valid_out;
    logic             w_ready_out;
    logic             w_accept;
    logic             w_last;
    logic [OUT_W-1:0] w_din_ext;
    logic [OUT_W-1:0] w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_accept && w_last) w_state_nxt = S_HOLD;
            // Draining result: a beat accepted in the same cycle opens the next group
            S_HOLD:  if (bus.ready_in) w_state_nxt = w_accept ? S_ACCUM : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_valid_out = (r_state == S_HOLD);
        w_ready_out = !(w_valid_out && !bus.ready_in);
        w_accept    = bus.valid_in && w_ready_out;
        w_last      = (r_state == S_ACCUM) && (r_cnt == LAST_CNT);
        w_din_ext   = {{(OUT_W - WIDTH){1'b0}}, bus.data_in};
        w_sum       = r_acc + w_din_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_data_out <= w_sum;
                r_acc      <= '0;
                r_cnt      <= '0;
            end else if (r_state == S_ACCUM) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_acc <= w_din_ext;
                r_cnt <= CNT_W'(1);
            end
        end
    end

    assign bus.ready_out = w_ready_out;
    assign bus.valid_out = w_valid_out;
    assign bus.data_out  = r_data_out;
endmodule

// File: tb/tb_accu_8bit.sv
// Randomised and directed bench for accu_8bit with a queue-based scoreboard
// fed by a group-sum reference model.
module tb_accu_8bit;
    localparam int WIDTH = 8;
    localparam int GROUP = 4;
    localparam int OUT_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accu_8bit_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();

    accu_8bit #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] got_q[$];
    int unsigned      beats[$];
    bit               m_hold = 1'b0;
    bit               m_acc  = 1'b0;
    int               m_groups = 0;
    int               vcycles  = 0;
    int               cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect accepted beats, emit their plain sum per group.
    always @(posedge clk) begin
        bit ready;
        int unsigned s;
        cyc++;
        m_acc = 1'b0;
        if (rst) begin
            beats.delete();
            exp_q.delete();
            m_hold = 1'b0;
        end else begin
            ready = !(m_hold && !bus.ready_in);
            if (m_hold && bus.ready_in) m_hold = 1'b0;
            if (bus.valid_in && ready) begin
                m_acc = 1'b1;
                beats.push_back(int'(bus.data_in));
                if (beats.size() == GROUP) begin
                    s = 0;
                    foreach (beats[k]) s += beats[k];
                    exp_q.push_back(s[OUT_W-1:0]);
                    beats.delete();
                    m_hold = 1'b1;
                    m_groups++;
                end
            end
        end
    end

    // Monitor: compares handshake and presented results away from the clock edge.
    always @(negedge clk) begin
        chk("ready_out", {31'd0, bus.ready_out}, {31'd0, !(m_hold && !bus.ready_in)});
        chk("valid_out", {31'd0, bus.valid_out}, {31'd0, m_hold});
        if (bus.valid_out) begin
            vcycles++;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {22'd0, bus.data_out}, 32'hFFFF_FFFF);
            end else begin
                chk("data_out", {22'd0, bus.data_out}, {22'd0, exp_q[0]});
                if (bus.ready_in && !rst) begin
                    got_q.push_back(bus.data_out);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_acc && n < 50);
        if (!m_acc) chk("beat_timeout", 32'(n), 32'd0);
        bus.valid_in = 1'b0;
    endtask

    task automatic expect_results(input string name, input int n,
                                  input logic [OUT_W-1:0] v0, input logic [OUT_W-1:0] v1);
        chk({name, "_count"}, 32'(got_q.size()), 32'(n));
        if (got_q.size() >= 1) chk({name, "_r0"}, {22'd0, got_q[0]}, {22'd0, v0});
        if (n > 1 && got_q.size() >= 2) chk({name, "_r1"}, {22'd0, got_q[1]}, {22'd0, v1});
        got_q.delete();
        vcycles = 0;
    endtask

    initial begin
        int c0, g0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.ready_in = 1'b1;
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        chk("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_ready_out", {31'd0, bus.ready_out}, 32'd1);
        chk("rst_data_out", {22'd0, bus.data_out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);

        // Four full-scale beats back to back
        for (int i = 0; i < 4; i++) send(8'hFF);
        tick(3);
        chk("ff_valid_cycles", 32'(vcycles), 32'd1);
        expect_results("ff", 1, 10'h3FC, '0);

        // Beats separated by idle gaps
        for (int i = 1; i <= 4; i++) begin
            send(8'(i));
            if (i < 4) begin
                tick(2);
                chk("gap_no_early_result", 32'(got_q.size()), 32'd0);
            end
        end
        tick(3);
        expect_results("gap", 1, 10'h00A, '0);

        // Downstream stall for five cycles
        bus.ready_in = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h10);
        tick(5);
        chk("stall_held", 32'(got_q.size()), 32'd0);
        bus.ready_in = 1'b1;
        tick(2);
        chk("stall_valid_cycles", 32'(vcycles), 32'd6);
        expect_results("stall", 1, 10'h040, '0);

        // Two groups with no bubble
        c0 = cyc;
        for (int i = 1; i <= 8; i++) send(8'(i));
        chk("b2b_cycles", 32'(cyc - c0), 32'd8);
        tick(3);
        expect_results("b2b", 2, 10'h00A, 10'h01A);

        // Reset mid-group with a beat presented during reset
        send(8'h55);
        send(8'h55);
        rst = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h77;
        tick(1);
        rst = 1'b0;
        bus.valid_in = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h01);
        tick(3);
        expect_results("rst_mid", 1, 10'h004, '0);

        // Random valid/ready traffic for 1000 groups
        g0 = m_groups;
        c0 = cyc;
        while ((m_groups - g0) < 1000 && (cyc - c0) < 60000) begin
            bus.ready_in = ($urandom_range(0, 9) < 7);
            bus.valid_in = ($urandom_range(0, 9) < 7) && ((m_groups - g0) < 1000);
            bus.data_in  = 8'($urandom);
            tick(1);
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        tick(4);
        chk("rand_groups", 32'(m_groups - g0), 32'd1000);
        chk("rand_results", 32'(got_q.size()), 32'd1000);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
